// File: rtl/game_sprite_control_pkg.sv
// Shared screen/sprite geometry for the sprite path: coordinate widths and the packed position type.
// The `X_WIDTH/`Y_WIDTH defaults live here so every file that imports the package sees the same values.
`ifndef GAME_CONFIG_VH
`define GAME_CONFIG_VH
`define SCREEN_WIDTH  640
`define SCREEN_HEIGHT 480
`define X_WIDTH       10
`define Y_WIDTH       10
`endif

package game_sprite_control_pkg;

  localparam int X_W = `X_WIDTH;
  localparam int Y_W = `Y_WIDTH;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } sprite_pos_t;

endpackage

// File: rtl/game_sprite_control_if.sv
// Write/position bundle between the game-logic FSM (master) and one sprite controller (slave).
interface game_sprite_control_if #(
  parameter int DX_WIDTH = 2,
  parameter int DY_WIDTH = 2
);
  import game_sprite_control_pkg::*;

  logic                sprite_write_xy;
  logic                sprite_write_dxy;
  logic [X_W-1:0]      sprite_write_x;
  logic [Y_W-1:0]      sprite_write_y;
  logic [DX_WIDTH-1:0] sprite_write_dx;
  logic [DY_WIDTH-1:0] sprite_write_dy;
  logic                sprite_enable_update;
  logic [X_W-1:0]      sprite_x;
  logic [Y_W-1:0]      sprite_y;
  logic                sprite_update_strobe;

  modport master (
    output sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
           sprite_write_dx, sprite_write_dy, sprite_enable_update,
    input  sprite_x, sprite_y, sprite_update_strobe
  );

  modport slave (
    input  sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
           sprite_write_dx, sprite_write_dy, sprite_enable_update,
    output sprite_x, sprite_y, sprite_update_strobe
  );
endinterface

// File: rtl/game_strobe_gen.sv
// Free-running period counter: while enabled, raises a one-cycle combinational tick every PERIOD cycles.
module game_strobe_gen #(
  parameter int               WIDTH  = 22,
  parameter logic [WIDTH-1:0] PERIOD = 22'd2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic strobe
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_end;

  // PERIOD==1 makes at_end permanently true, giving a tick on every enabled cycle.
  assign at_end = (cnt_q == (PERIOD - WIDTH'(1)));
  assign strobe = enable && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = at_end ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_sprite_control.sv
// One sprite's position/velocity registers; position steps by velocity on each internal update tick.
module game_sprite_control
  import game_sprite_control_pkg::*;
#(
  parameter int                      DX_WIDTH      = 2,
  parameter int                      DY_WIDTH      = 2,
  parameter int                      STROBE_WIDTH  = 22,
  parameter logic [STROBE_WIDTH-1:0] STROBE_PERIOD = 22'd2500000
) (
  input  logic                  clk,
  input  logic                  reset,
  game_sprite_control_if.slave  sprite_if
);

  sprite_pos_t         pos_q, pos_d;
  logic [DX_WIDTH-1:0] dx_q, dx_d;
  logic [DY_WIDTH-1:0] dy_q, dy_d;
  logic                strobe_q;
  logic                tick;

  game_strobe_gen #(
    .WIDTH  (STROBE_WIDTH),
    .PERIOD (STROBE_PERIOD)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .enable (sprite_if.sprite_enable_update),
    .strobe (tick)
  );

  // Velocity is sign-extended and added modulo the coordinate width; wrap-around is deliberate.
  always_comb begin
    pos_d = pos_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    if (tick) begin
      pos_d.x = pos_q.x + {{(X_W-DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q};
      pos_d.y = pos_q.y + {{(Y_W-DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q};
    end
    if (sprite_if.sprite_write_xy) begin
      pos_d.x = sprite_if.sprite_write_x;
      pos_d.y = sprite_if.sprite_write_y;
    end
    if (sprite_if.sprite_write_dxy) begin
      dx_d = sprite_if.sprite_write_dx;
      dy_d = sprite_if.sprite_write_dy;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      strobe_q <= tick;
    end
  end

  assign sprite_if.sprite_x             = pos_q.x;
  assign sprite_if.sprite_y             = pos_q.y;
  assign sprite_if.sprite_update_strobe = strobe_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Directed bench for game_sprite_control with a 4-cycle update period.
module tb_game_sprite_control;
  import game_sprite_control_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  game_sprite_control_if #(.DX_WIDTH(2), .DY_WIDTH(2)) sif ();

  game_sprite_control #(
    .DX_WIDTH      (2),
    .DY_WIDTH      (2),
    .STROBE_WIDTH  (22),
    .STROBE_PERIOD (22'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sprite_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, int'(sif.sprite_x), ex);
    check({tag, ".y"}, int'(sif.sprite_y), ey);
    $display("%s: x=%0d y=%0d strobe=%0b", tag, sif.sprite_x, sif.sprite_y, sif.sprite_update_strobe);
  endtask

  // Steps until the update strobe is seen (bounded) and checks how many edges it took.
  task automatic wait_strobe(input string tag, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (sif.sprite_update_strobe !== 1'b1 && n < 30);
    check({tag, ".cycles"}, n, exp_cycles);
  endtask

  task automatic idle_writes();
    sif.sprite_write_xy  = 1'b0;
    sif.sprite_write_dxy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    sif.sprite_write_xy      = 1'b1;
    sif.sprite_write_dxy     = 1'b1;
    sif.sprite_write_x       = 10'd5;
    sif.sprite_write_y       = 10'd5;
    sif.sprite_write_dx      = 2'b01;
    sif.sprite_write_dy      = 2'b01;
    sif.sprite_enable_update = 1'b1;

    // Reset held with writes active: outputs stay cleared.
    for (int i = 0; i < 5; i++) begin
      step();
      check_pos("reset_hold", 0, 0);
      check("reset_hold.strobe", int'(sif.sprite_update_strobe), 0);
    end

    // Release reset while loading (10,20) with velocity (+1,-1).
    reset = 1'b1;
    sif.sprite_write_x  = 10'd10;
    sif.sprite_write_y  = 10'd20;
    sif.sprite_write_dx = 2'b01;
    sif.sprite_write_dy = 2'b11;
    step();
    check_pos("load", 10, 20);
    check("load.strobe", int'(sif.sprite_update_strobe), 0);
    idle_writes();

    wait_strobe("move1", 3);
    check_pos("move1", 11, 19);
    wait_strobe("move2", 4);
    check_pos("move2", 12, 18);
    wait_strobe("move3", 4);
    check_pos("move3", 13, 17);

    // Reset one cycle after the strobe; velocity cleared so position stays at origin.
    reset = 1'b0;
    step();
    check_pos("midreset", 0, 0);
    check("midreset.strobe", int'(sif.sprite_update_strobe), 0);
    reset = 1'b1;
    wait_strobe("postreset", 4);
    check_pos("postreset", 0, 0);

    // Wrap-around: (0,0) with velocity (-1,-1).
    sif.sprite_write_xy  = 1'b1;
    sif.sprite_write_dxy = 1'b1;
    sif.sprite_write_x   = 10'd0;
    sif.sprite_write_y   = 10'd0;
    sif.sprite_write_dx  = 2'b11;
    sif.sprite_write_dy  = 2'b11;
    step();
    check_pos("wrap_load", 0, 0);
    idle_writes();
    wait_strobe("wrap", 3);
    check_pos("wrap", 1023, 1023);

    // Freeze with counter at 2.
    step();
    step();
    check("prefreeze.strobe", int'(sif.sprite_update_strobe), 0);
    sif.sprite_enable_update = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("freeze.strobe", int'(sif.sprite_update_strobe), 0);
    end
    check_pos("freeze", 1023, 1023);
    sif.sprite_enable_update = 1'b1;
    wait_strobe("unfreeze", 2);
    check_pos("unfreeze", 1022, 1022);

    // Collision: velocity (+1,+1), then write xy and dxy on the tick cycle.
    sif.sprite_write_dxy = 1'b1;
    sif.sprite_write_dx  = 2'b01;
    sif.sprite_write_dy  = 2'b01;
    step();
    idle_writes();
    check_pos("vel_write", 1022, 1022);
    step();
    step();
    check("precollide.strobe", int'(sif.sprite_update_strobe), 0);
    sif.sprite_write_xy  = 1'b1;
    sif.sprite_write_dxy = 1'b1;
    sif.sprite_write_x   = 10'd50;
    sif.sprite_write_y   = 10'd60;
    sif.sprite_write_dx  = 2'b11;
    sif.sprite_write_dy  = 2'b01;
    step();
    idle_writes();
    check_pos("collide", 50, 60);
    check("collide.strobe", int'(sif.sprite_update_strobe), 1);
    step();
    check("collide.pulse_end", int'(sif.sprite_update_strobe), 0);
    wait_strobe("after_collide", 3);
    check_pos("after_collide", 49, 61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sprite_control.md
Name: game_sprite_control

Overview:
- Upstream stage of the per-sprite pixel renderer.
- Owns one sprite's position (sprite_x, sprite_y) and velocity (dx, dy).
- Accepts position/velocity writes from game-logic FSM; advances position by velocity once per internally generated update strobe.
- sprite_x/sprite_y drive renderer position inputs directly; sprite_update_strobe lets game logic sample renderer's registered bounds/within-screen flags after each move.

Parameters:
- DX_WIDTH, 2, width of signed x velocity (two's complement).
- DY_WIDTH, 2, width of signed y velocity (two's complement).
- STROBE_WIDTH, 22, width of update-period counter.
- STROBE_PERIOD, 22'd2500000, clocks per position update while enabled; legal range 1..2^STROBE_WIDTH-1.
- X/Y widths come from `X_WIDTH / `Y_WIDTH in game_config.vh, not parameters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; name kept as codebase convention, polarity low.
- sprite_write_xy  in  1  load sprite_write_x/y into position this cycle.
- sprite_write_dxy  in  1  load sprite_write_dx/dy into velocity this cycle.
- sprite_write_x  in  `X_WIDTH  new x position.
- sprite_write_y  in  `Y_WIDTH  new y position.
- sprite_write_dx  in  DX_WIDTH  new signed x velocity.
- sprite_write_dy  in  DY_WIDTH  new signed y velocity.
- sprite_enable_update  in  1  1 = motion enabled, 0 = frozen.
- sprite_x  out  `X_WIDTH  current x position (registered).
- sprite_y  out  `Y_WIDTH  current y position (registered).
- sprite_update_strobe  out  1  one-cycle pulse, cycle after position advanced by velocity.

Behaviour:
- Reset (reset==0 at posedge clk): sprite_x=0, sprite_y=0, dx=0, dy=0, strobe counter=0, sprite_update_strobe=0. Reset has priority over every other input.
- Strobe counter:
  - enable_update=1: increments each cycle; on reaching STROBE_PERIOD-1 wraps to 0 and raises internal tick for that cycle.
  - enable_update=0: holds value; no tick.
  - STROBE_PERIOD=1: tick every enabled cycle.
- Position update on tick:
  - x <= x + sign_extend(dx), y <= y + sign_extend(dy).
  - Arithmetic modulo 2^`X_WIDTH / 2^`Y_WIDTH; wrap-around intended (x=0, dx=-1 -> x=2^`X_WIDTH-1).
  - Off-screen detection is the renderer's job, not this block's.
- sprite_update_strobe: registered copy of tick; high exactly the cycle sprite_x/y first show the advanced value.
- Write priority, same cycle:
  - write_xy and tick: write wins; loaded value shown, no velocity added; sprite_update_strobe still pulses.
  - write_dxy and tick: advance uses old velocity; new velocity applies from next tick.
  - write_xy and write_dxy: both load independently.
- Latency: any write visible on outputs one clock later.
- Velocity registers change only on write_dxy or reset.
- Mid-operation reset: counter restarts at 0; first tick after release occurs STROBE_PERIOD enabled cycles later.

Decomposition:
- Shared: `X_WIDTH, `Y_WIDTH, `SCREEN_WIDTH, `SCREEN_HEIGHT from game_config.vh. Add `SPRITE_DXY_WIDTH default there if several sprites share it.
- One sub-module: game_strobe_gen (params WIDTH, PERIOD; ports clk, reset, enable, strobe). Counter+tick only; reusable by other timers.
- Position/velocity registers and adders stay in game_sprite_control.

Test Plan:
- Reset: bench STROBE_PERIOD=4; hold reset=0 5 cycles with writes active -> sprite_x=0, sprite_y=0, sprite_update_strobe=0 throughout.
- Basic motion: write xy=(10,20), dxy=(+1,-1), enable=1 -> strobe every 4 cycles; position (11,19), (12,18), (13,17) after 1st, 2nd, 3rd pulses.
- Wrap-around: write x=0, y=0, dx=-1, dy=-1 -> after one tick x=2^`X_WIDTH-1, y=2^`Y_WIDTH-1.
- Freeze: enable=0 for 10 cycles mid-count (counter=2) -> no strobe, position constant. Re-enable -> next strobe exactly 2 cycles later.
- Collisions: at tick cycle assert write_xy=(50,60) and write_dxy=(-1,+1) with old velocity (+1,+1) -> position (50,60), strobe pulses. Next tick -> (49,61).
- Reset mid-run: assert reset=0 one cycle after strobe with position (13,17) -> next cycle (0,0). After release first strobe after 4 enabled cycles, position unchanged at (0,0) since velocity cleared.
